// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
//   Frame-level controller for the 3x3 window memory and convolution datapath.
//   A start command in IDLE walks every window origin of an IMG_H x IMG_W
//   output frame in raster order and issues one read strobe per origin. Each
//   origin travels down a PIPE_LAT-deep coordinate pipeline and comes out as
//   the matching write strobe plus output coordinate. stall freezes the walk
//   and the pipeline together.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   start    : begin one frame (sampled in IDLE only)
//   stall    : freeze counters and write pipeline, mask both strobes
//   rd_en    : window read strobe
//   rd_row   : window origin row of current read
//   rd_col   : window origin column of current read
//   wr_en    : result write strobe
//   wr_row   : output row of current write
//   wr_col   : output column of current write
//   busy     : high from RUN entry through the done cycle
//   done     : one-cycle pulse once the whole frame is written
//   wr_count : writes issued in the current / last frame
module conv_frame_sequencer #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int PIPE_LAT = 3,
  parameter int AW       = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  output logic            rd_en,
  output logic [AW-1:0]   rd_row,
  output logic [AW-1:0]   rd_col,
  output logic            wr_en,
  output logic [AW-1:0]   wr_row,
  output logic [AW-1:0]   wr_col,
  output logic            busy,
  output logic            done,
  output logic [2*AW-1:0] wr_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW-1:0]   LAST_ROW = AW'(IMG_H - 1);
  localparam logic [AW-1:0]   LAST_COL = AW'(IMG_W - 1);
  localparam logic [AW-1:0]   ONE_AW   = AW'(1);
  localparam logic [2*AW-1:0] ONE_CNT  = (2*AW)'(1);

  state_t state_q, state_d;

  logic            rd_en_q, busy_q, done_q;
  logic [AW-1:0]   rd_row_q, rd_col_q;
  logic [2*AW-1:0] wr_count_q;

  logic [PIPE_LAT-1:0] vld_p;
  logic [AW-1:0]       row_p [PIPE_LAT];
  logic [AW-1:0]       col_p [PIPE_LAT];

  logic last_origin;
  logic pipe_drained;
  logic launch;

  // Raster advance of a window origin: {row, col}.
  function automatic logic [2*AW-1:0] next_origin(input logic [AW-1:0] row,
                                                  input logic [AW-1:0] col);
    if (col == LAST_COL) return {row + ONE_AW, {AW{1'b0}}};
    else                 return {row, col + ONE_AW};
  endfunction

  assign launch      = (state_q == IDLE) && start;
  assign last_origin = (rd_row_q == LAST_ROW) && (rd_col_q == LAST_COL);
  // After one more shift with nothing entering, no valid entry remains.
  assign pipe_drained = ((vld_p << 1) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!stall && last_origin) state_d = DRAIN;
      DRAIN:   if (!stall && pipe_drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= (state_d == RUN);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // Origin counter holds on the final origin so it never leaves the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_row_q <= '0;
      rd_col_q <= '0;
    end else if (launch) begin
      rd_row_q <= '0;
      rd_col_q <= '0;
    end else if (state_q == RUN && !stall && !last_origin) begin
      {rd_row_q, rd_col_q} <= next_origin(rd_row_q, rd_col_q);
    end
  end

  // Stage 0 captures the origin being read; stage PIPE_LAT-1 drives the write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        row_p[i] <= '0;
        col_p[i] <= '0;
      end
    end else if (!stall) begin
      vld_p[0] <= (state_q == RUN);
      row_p[0] <= rd_row_q;
      col_p[0] <= rd_col_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        row_p[i] <= row_p[i-1];
        col_p[i] <= col_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      wr_count_q <= '0;
    else if (launch) wr_count_q <= '0;
    else if (wr_en)  wr_count_q <= wr_count_q + ONE_CNT;
  end

  // Strobes are masked by stall in the same cycle so a stalled origin is
  // neither read nor written until it is presented again.
  assign rd_en    = rd_en_q & ~stall;
  assign rd_row   = rd_row_q;
  assign rd_col   = rd_col_q;
  assign wr_en    = vld_p[PIPE_LAT-1] & ~stall;
  assign wr_row   = row_p[PIPE_LAT-1];
  assign wr_col   = col_p[PIPE_LAT-1];
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
module tb_conv_frame_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int L  = 3;
  localparam int AW = 7;
  localparam int N  = W * H;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            stall = 1'b0;
  logic            rd_en, wr_en, busy, done;
  logic [AW-1:0]   rd_row, rd_col, wr_row, wr_col;
  logic [2*AW-1:0] wr_count;

  conv_frame_sequencer #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(L), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int idx; int row; int col;} ent_t;
  ent_t rdq[$];
  ent_t wrq[$];
  int   doneq[$];

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_rd_cyc = 0;
  int first_wr_cyc = 0;
  bit prev_done = 1'b0;
  ent_t me;
  int   mn;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (rd_en) begin
      if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        me = rdq.pop_front();
        chk("rd_row", int'(rd_row), me.row);
        chk("rd_col", int'(rd_col), me.col);
        if (me.idx == 0) first_rd_cyc = cyc;
      end
      chk("busy_with_rd", int'(busy), 1);
    end
    if (wr_en) begin
      if (wrq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        me = wrq.pop_front();
        chk("wr_row", int'(wr_row), me.row);
        chk("wr_col", int'(wr_col), me.col);
        chk("wr_count_run", int'(wr_count), me.idx);
        if (me.idx == 0) first_wr_cyc = cyc;
      end
    end
    if (done) begin
      if (doneq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        mn = doneq.pop_front();
        chk("done_wr_count", int'(wr_count), mn);
        chk("done_busy", int'(busy), 1);
      end
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_done) begin
      chk("busy_after_done", int'(busy), 0);
      chk("done_single_pulse", int'(done), 0);
    end
    prev_done = done;
    if (stall) chk("strobes_in_stall", int'({rd_en, wr_en}), 0);
  end

  task automatic push_frame(input int nrd, input int nwr, input bit with_done);
    for (int i = 0; i < nrd; i++) rdq.push_back('{i, i / W, i % W});
    for (int i = 0; i < nwr; i++) wrq.push_back('{i, i / W, i % W});
    if (with_done) doneq.push_back(N);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"},    int'(rd_en),    0);
    chk({tag, "_wr_en"},    int'(wr_en),    0);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_done"},     int'(done),     0);
    chk({tag, "_rd_row"},   int'(rd_row),   0);
    chk({tag, "_rd_col"},   int'(rd_col),   0);
    chk({tag, "_wr_row"},   int'(wr_row),   0);
    chk({tag, "_wr_col"},   int'(wr_col),   0);
    chk({tag, "_wr_count"}, int'(wr_count), 0);
  endtask

  // Called just after a rising edge. Stall covers relative cycles
  // [st0, st0+nst); hold keeps start high for the whole frame.
  task automatic run_frame(input int st0, input int nst, input bit hold);
    int s, d0, rel;
    bit got;
    push_frame(N, N, 1'b1);
    start = 1'b1;
    s = cyc;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge clk); #1;
      rel = cyc - s;
      if (!hold) start = 1'b0;
      stall = (rel >= st0) && (rel < st0 + nst);
      if (done_cnt != d0) got = 1'b1;
    end
    stall = 1'b0;
    if (!got) chk("frame_timeout", 0, 1);
    else      chk("done_cycle", done_cyc - s, 16 + nst);
    chk("first_rd_cycle", first_rd_cyc - s, 1);
    if (nst == 0) chk("first_wr_cycle", first_wr_cyc - s, 1 + L);
    chk("rd_left", rdq.size(), 0);
    chk("wr_left", wrq.size(), 0);
    chk("done_left", doneq.size(), 0);
  endtask

  initial begin
    int s, d0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_quiet", int'({rd_en, wr_en, busy, done}), 0);
      chk("idle_coords", int'({rd_row, rd_col, wr_row, wr_col}), 0);
    end

    @(posedge clk); #1;
    run_frame(99, 0, 1'b0);   // plain frame
    run_frame(3, 2, 1'b0);    // stall while (0,2) is presented
    run_frame(13, 3, 1'b0);   // stall during drain
    run_frame(99, 0, 1'b1);   // start held through DONE
    run_frame(99, 0, 1'b0);   // start in first IDLE cycle: second frame

    // Abort: reset in cycle 7 of a frame.
    push_frame(7, 4, 1'b0);
    start = 1'b1;
    s = cyc;
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("abort");
    chk("abort_cycle", cyc - s, 8);
    chk("abort_rd_left", rdq.size(), 0);
    chk("abort_wr_left", wrq.size(), 0);
    chk("abort_no_done", done_cnt, d0);
    rdq.delete();
    wrq.delete();

    @(posedge clk); #1;
    run_frame(99, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", int'({rd_en, wr_en, busy, done}), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
